// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: word width and the
// {pc, instr} entry carried through the prefetch queue.
package fetch_pkg;

    localparam int WORD_W = 32;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush. Pointers wrap
// naturally; a separate count distinguishes full from empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  fetch_entry_t                   push_data,
    input  logic                           pop,
    input  logic                           flush,
    output fetch_entry_t                   head,
    output logic                           head_valid,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic [LW-1:0]   count;
    logic            pop_ok;
    logic            push_ok;

    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & ((count != LW'(DEPTH)) | pop_ok);

    // A flush keeps the read pointer (after any same-cycle pop) so the
    // head registers keep showing the last word while the queue is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            rptr <= rptr + PW'(pop_ok);
            if (flush) begin
                wptr  <= rptr + PW'(pop_ok);
                count <= '0;
            end else begin
                if (push_ok) begin
                    mem[wptr] <= push_data;
                end
                wptr  <= wptr + PW'(push_ok);
                count <= count + LW'(push_ok) - LW'(pop_ok);
            end
        end
    end

    assign head       = mem[rptr];
    assign head_valid = (count != '0);
    assign level      = count;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the pc, reads the combinational ROM, and buffers
// {pc, instr} pairs for decode. Redirects flush the queue and reload pc.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int unsigned MEM_WORDS = 32,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [WORD_W-1:0]            imem_addr,
    input  logic [WORD_W-1:0]            imem_data,
    input  logic                         redirect_valid,
    input  logic [WORD_W-1:0]            redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_instr,
    output logic [WORD_W-1:0]            out_pc,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         halted
);

    localparam int LW = $clog2(DEPTH+1);

    logic [WORD_W-1:0] pc;
    logic              pc_in_range;
    logic              pop;
    logic              fetch_en;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Handshake: a word transfers to decode on any edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and a
    // pop coincident with a redirect is still a completed transfer.
    assign pop         = out_valid & out_ready;
    assign pc_in_range = (pc < WORD_W'(MEM_WORDS));
    assign fetch_en    = pc_in_range & ((level < LW'(DEPTH)) | pop) & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= WORD_W'(RESET_PC);
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (fetch_en) begin
            pc <= pc + 1'b1;
        end
    end

    assign push_entry.pc    = pc;
    assign push_entry.instr = imem_data;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fetch_en),
        .push_data  (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .head_valid (out_valid),
        .level      (level)
    );

    assign imem_addr = pc;
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign halted    = ~pc_in_range & (level == '0);

endmodule
